// File: rtl/fifo_rd_ctrl.sv
// Read-domain half of the asynchronous FIFO: synchronises the Gray write pointer,
// owns the read pointer and RAM read port, and derives empty/almost-empty/count.
`timescale 1ns/1ps
module fifo_rd_ctrl #(
    parameter int ADDR_WIDTH      = 4,
    parameter int DATA_WIDTH      = 8,
    parameter int PTR_WIDTH       = ADDR_WIDTH + 1,
    parameter int SYNC_STAGES     = 2,
    parameter int ALMOST_EMPTY_TH = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [PTR_WIDTH-1:0]  i_wr_ptr_gray,
    input  logic                  i_rd_en,
    output logic                  o_ram_rd_en,
    output logic [ADDR_WIDTH-1:0] o_ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] i_ram_rd_data,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_rd_valid,
    output logic [PTR_WIDTH-1:0]  o_rd_ptr_gray,
    output logic                  o_empty,
    output logic                  o_almost_empty,
    output logic [PTR_WIDTH-1:0]  o_rd_count,
    output logic                  o_underflow
);

    typedef logic [PTR_WIDTH-1:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic ptr_t gray2bin(input ptr_t gray);
        ptr_t bin;
        bin = gray;
        for (int i = PTR_WIDTH - 2; i >= 0; i--) begin
            bin[i] = gray[i] ^ bin[i+1];
        end
        return bin;
    endfunction

    // Stage 0 samples the asynchronous pointer; no logic may sit between stages.
    logic [SYNC_STAGES-1:0][PTR_WIDTH-1:0] wr_sync_q, wr_sync_d;

    ptr_t wr_bin_sync;
    logic accept;

    ptr_t rd_bin_q,  rd_bin_d;
    ptr_t rd_gray_q, rd_gray_d;
    ptr_t count_q,   count_d;
    logic empty_q,        empty_d;
    logic almost_empty_q, almost_empty_d;
    logic rd_valid_q,     rd_valid_d;
    logic underflow_q,    underflow_d;

    // NOTE: every signal below is assigned on every path, so no latch can be inferred.
    always_comb begin
        wr_sync_d      = {wr_sync_q[SYNC_STAGES-2:0], i_wr_ptr_gray};
        wr_bin_sync    = gray2bin(wr_sync_q[SYNC_STAGES-1]);

        accept         = i_rd_en & ~empty_q;
        rd_bin_d       = rd_bin_q + ptr_t'(accept);
        rd_gray_d      = bin2gray(rd_bin_d);

        // Flags look at the post-read pointer so back-to-back reads cannot pass empty.
        count_d        = wr_bin_sync - rd_bin_d;
        empty_d        = (count_d == '0);
        almost_empty_d = (count_d <= ptr_t'(ALMOST_EMPTY_TH));

        rd_valid_d     = accept;
        underflow_d    = i_rd_en & empty_q;
    end

    // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_sync_q      <= '0;
            rd_bin_q       <= '0;
            rd_gray_q      <= '0;
            count_q        <= '0;
            empty_q        <= 1'b1;
            almost_empty_q <= 1'b1;
            rd_valid_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            wr_sync_q      <= wr_sync_d;
            rd_bin_q       <= rd_bin_d;
            rd_gray_q      <= rd_gray_d;
            count_q        <= count_d;
            empty_q        <= empty_d;
            almost_empty_q <= almost_empty_d;
            rd_valid_q     <= rd_valid_d;
            underflow_q    <= underflow_d;
        end
    end

    assign o_ram_rd_en    = accept;
    assign o_ram_rd_addr  = rd_bin_q[ADDR_WIDTH-1:0];
    assign o_rd_data      = i_ram_rd_data;
    assign o_rd_valid     = rd_valid_q;
    assign o_rd_ptr_gray  = rd_gray_q;
    assign o_empty        = empty_q;
    assign o_almost_empty = almost_empty_q;
    assign o_rd_count     = count_q;
    assign o_underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Scoreboard bench for fifo_rd_ctrl: stimulus pushes expected read words, a
// negedge monitor pops and compares them whenever o_rd_valid is presented.
`timescale 1ns/1ps
module tb_fifo_rd_ctrl;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int PW = AW + 1;

    logic          clk;
    logic          i_rst;
    logic [PW-1:0] i_wr_ptr_gray;
    logic          i_rd_en;
    logic          o_ram_rd_en;
    logic [AW-1:0] o_ram_rd_addr;
    logic [DW-1:0] i_ram_rd_data;
    logic [DW-1:0] o_rd_data;
    logic          o_rd_valid;
    logic [PW-1:0] o_rd_ptr_gray;
    logic          o_empty;
    logic          o_almost_empty;
    logic [PW-1:0] o_rd_count;
    logic          o_underflow;

    fifo_rd_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PTR_WIDTH(PW),
        .SYNC_STAGES(2), .ALMOST_EMPTY_TH(2)
    ) dut (
        .i_clk(clk), .i_rst(i_rst), .i_wr_ptr_gray(i_wr_ptr_gray), .i_rd_en(i_rd_en),
        .o_ram_rd_en(o_ram_rd_en), .o_ram_rd_addr(o_ram_rd_addr),
        .i_ram_rd_data(i_ram_rd_data), .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid),
        .o_rd_ptr_gray(o_rd_ptr_gray), .o_empty(o_empty), .o_almost_empty(o_almost_empty),
        .o_rd_count(o_rd_count), .o_underflow(o_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM contents and the bench's own synchronous-read RAM model.
    logic [DW-1:0] mem [16] = '{8'h3C, 8'hA5, 8'h0F, 8'hF0, 8'h5A, 8'hC3, 8'h96, 8'h69,
                                8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hE1};
    always @(posedge clk) begin
        if (o_ram_rd_en) i_ram_rd_data <= mem[o_ram_rd_addr];
    end

    int n_pass  = 0;
    int n_total = 0;
    logic [DW-1:0] sb [$];
    logic [DW-1:0] mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PW-1:0] gray5(input int b);
        logic [PW-1:0] x;
        x = PW'(b);
        return x ^ (x >> 1);
    endfunction

    always @(negedge clk) begin
        if (o_rd_valid) begin
            if (sb.size() == 0) begin
                check("rd_valid_without_expected_word", sb.size(), 1);
            end else begin
                mon_exp = sb.pop_front();
                check("rd_data", {24'd0, o_rd_data}, {24'd0, mon_exp});
            end
        end
    end

    // Wrap-test model state
    int wr, m_rd, m_s0, m_s1, m_count, new_count;
    logic acc, last_acc, m_uf;
    logic [PW-1:0] prev_gray;

    initial begin
        i_rst = 1'b1; i_wr_ptr_gray = '0; i_rd_en = 1'b0;

        // Reset state
        #1;
        check("rst_empty", o_empty, 1);
        check("rst_aempty", o_almost_empty, 1);
        check("rst_count", o_rd_count, 0);
        check("rst_valid", o_rd_valid, 0);
        check("rst_gray", o_rd_ptr_gray, 0);
        check("rst_uflow", o_underflow, 0);
        tick(); tick();
        i_rst = 1'b0;

        // Write visibility: 3 edges from pointer change to flags
        i_wr_ptr_gray = 5'b00001;
        tick(); check("wv_empty_e1", o_empty, 1);
        tick(); check("wv_empty_e2", o_empty, 1); check("wv_count_e2", o_rd_count, 0);
        tick(); check("wv_empty_e3", o_empty, 0); check("wv_count_e3", o_rd_count, 1);
        check("wv_aempty_e3", o_almost_empty, 1);

        // Single read
        i_rd_en = 1'b1;
        #1;
        check("sr_ram_en", o_ram_rd_en, 1);
        check("sr_ram_addr", o_ram_rd_addr, 0);
        sb.push_back(mem[0]);
        tick();
        i_rd_en = 1'b0;
        check("sr_valid", o_rd_valid, 1);
        check("sr_empty", o_empty, 1);
        check("sr_gray", o_rd_ptr_gray, 5'b00001);
        check("sr_count", o_rd_count, 0);
        check("sr_uflow", o_underflow, 0);
        tick();
        check("sr_valid_drop", o_rd_valid, 0);

        // Async reset mid-transfer
        i_wr_ptr_gray = 5'b00110;  // binary 4 -> count 3
        tick(); tick(); tick();
        check("ar_count", o_rd_count, 3);
        check("ar_aempty", o_almost_empty, 0);
        i_rd_en = 1'b1;
        #1;
        check("ar_ram_addr", o_ram_rd_addr, 1);
        sb.push_back(mem[1]);
        tick();
        i_rd_en = 1'b0;
        check("ar_valid_before", o_rd_valid, 1);
        i_rst = 1'b1;
        i_wr_ptr_gray = '0;
        #1;
        check("ar_valid", o_rd_valid, 0);
        check("ar_empty", o_empty, 1);
        check("ar_aempty_rst", o_almost_empty, 1);
        check("ar_gray", o_rd_ptr_gray, 0);
        check("ar_count_rst", o_rd_count, 0);
        sb.delete();
        tick(); tick();
        i_rst = 1'b0;

        // Full drain of 16 words with 4 excess requests
        i_wr_ptr_gray = 5'b11000;
        tick(); tick(); tick();
        check("fd_count16", o_rd_count, 16);
        check("fd_aempty", o_almost_empty, 0);
        check("fd_empty", o_empty, 0);
        i_rd_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            int exp_cnt;
            #1;
            exp_cnt = (i < 16) ? 16 - i : 0;
            check("fd_count", o_rd_count, exp_cnt);
            check("fd_empty_i", o_empty, exp_cnt == 0);
            check("fd_aempty_i", o_almost_empty, exp_cnt <= 2);
            check("fd_valid", o_rd_valid, (i >= 1 && i <= 16));
            check("fd_uflow", o_underflow, i >= 17);
            check("fd_ram_en", o_ram_rd_en, i < 16);
            check("fd_gray_i", o_rd_ptr_gray, gray5((i < 16) ? i : 16));
            if (i < 16) begin
                check("fd_ram_addr", o_ram_rd_addr, i);
                sb.push_back(mem[i]);
            end
            tick();
        end
        i_rd_en = 1'b0;
        check("fd_uflow_last", o_underflow, 1);
        check("fd_gray_final", o_rd_ptr_gray, 5'b11000);
        check("fd_empty_final", o_empty, 1);
        tick();
        check("fd_uflow_clear", o_underflow, 0);

        // Underflow isolation
        i_rd_en = 1'b1;
        #1;
        check("uf_ram_en", o_ram_rd_en, 0);
        tick();
        i_rd_en = 1'b0;
        check("uf_pulse", o_underflow, 1);
        check("uf_valid", o_rd_valid, 0);
        check("uf_count", o_rd_count, 0);
        check("uf_gray", o_rd_ptr_gray, 5'b11000);
        tick();
        check("uf_pulse_end", o_underflow, 0);
        check("uf_gray_hold", o_rd_ptr_gray, 5'b11000);

        // Wrap-around stream of 40 words through binary 31 -> 0
        wr = 16; m_rd = 16; m_s0 = 16; m_s1 = 16; m_count = 0;
        last_acc = 1'b0; m_uf = 1'b0; prev_gray = 5'b11000;
        for (int cyc = 0; cyc < 400; cyc++) begin
            check("wr_count", o_rd_count, m_count);
            check("wr_empty", o_empty, m_count == 0);
            check("wr_aempty", o_almost_empty, m_count <= 2);
            check("wr_gray", o_rd_ptr_gray, gray5(m_rd));
            check("wr_hamming", $countones(o_rd_ptr_gray ^ prev_gray), last_acc ? 1 : 0);
            check("wr_valid", o_rd_valid, last_acc);
            check("wr_uflow", o_underflow, m_uf);
            prev_gray = o_rd_ptr_gray;
            if (m_rd == 56) break;

            if (wr != 56 && (wr - m_rd) < 16 && (cyc % 4) != 3) wr++;
            i_wr_ptr_gray = gray5(wr);
            i_rd_en = ((cyc % 3) != 2);
            acc  = i_rd_en && (m_count != 0);
            m_uf = i_rd_en && (m_count == 0);
            #1;
            check("wr_ram_en", o_ram_rd_en, acc);
            if (acc) begin
                check("wr_ram_addr", o_ram_rd_addr, m_rd % 16);
                sb.push_back(mem[m_rd % 16]);
            end
            new_count = m_s1 - (m_rd + int'(acc));
            m_s1 = m_s0;
            m_s0 = wr;
            m_rd = m_rd + int'(acc);
            m_count = new_count;
            last_acc = acc;
            tick();
        end
        i_rd_en = 1'b0;
        tick(); tick();
        check("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fifo_rd_ctrl.md
Name: fifo_rd_ctrl

Overview:
Read-side pointer and flag controller for the team's asynchronous FIFO; runs entirely in the read clock domain.
- Synchronises the incoming Gray-coded write pointer and converts it to binary.
- Maintains the read pointer and drives the dual-port RAM read port.
- Produces empty, almost-empty and fill count.
- Returns its own Gray-coded read pointer to the write domain.

Parameters:
ADDR_WIDTH, 4, RAM address width; FIFO depth = 2^ADDR_WIDTH.
DATA_WIDTH, 8, RAM/output data width.
PTR_WIDTH, ADDR_WIDTH+1, pointer width; extra MSB is the wrap bit.
SYNC_STAGES, 2, flop stages on the incoming write pointer; legal values are 2 and 3.
ALMOST_EMPTY_TH, 2, almost-empty asserts when fill count <= this value.

Ports:
i_clk  input  1  read-domain clock.
i_rst  input  1  reset, asynchronous, active-high.
i_wr_ptr_gray  input  PTR_WIDTH  Gray write pointer from write domain; asynchronous to i_clk.
i_rd_en  input  1  read request.
o_ram_rd_en  output  1  RAM read enable.
o_ram_rd_addr  output  ADDR_WIDTH  RAM read address.
i_ram_rd_data  input  DATA_WIDTH  RAM read data; valid 1 cycle after o_ram_rd_en.
o_rd_data  output  DATA_WIDTH  read data to consumer.
o_rd_valid  output  1  o_rd_data valid strobe.
o_rd_ptr_gray  output  PTR_WIDTH  registered Gray read pointer to write domain.
o_empty  output  1  FIFO empty.
o_almost_empty  output  1  fill count <= ALMOST_EMPTY_TH.
o_rd_count  output  PTR_WIDTH  fill count, 0..2^ADDR_WIDTH.
o_underflow  output  1  one-cycle pulse: read attempted while empty.

Behaviour:
Reset values (asynchronous, applied while i_rst=1):
- All pointers, sync flops, o_rd_ptr_gray, o_rd_count, o_rd_valid and o_underflow = 0.
- o_empty = 1, o_almost_empty = 1.
- i_rst asserted mid-transfer discards any in-flight o_rd_valid.

Write-pointer synchronisation and conversion:
- i_wr_ptr_gray passes through a SYNC_STAGES flop chain with no logic between stages.
- The synchronised value is converted Gray-to-binary: MSB passes through; each lower bit = Gray bit XOR the next-higher binary bit.

Read acceptance:
- accept = i_rd_en & ~o_empty.
- o_ram_rd_en = accept and o_ram_rd_addr = rd_bin[ADDR_WIDTH-1:0]; both combinational, same cycle.
- On accept, rd_bin <= rd_bin + 1. The PTR_WIDTH-wide pointer wraps modulo 2^PTR_WIDTH.

Read pointer output:
- o_rd_ptr_gray <= bin2gray(rd_bin_next), registered on the same edge as rd_bin.
- bin2gray(x) = x ^ (x >> 1).
- Exactly one bit changes per increment, including the 2^PTR_WIDTH-1 -> 0 wrap.

Data path:
- o_rd_valid <= accept, so it asserts 1 cycle after accept.
- o_rd_data = i_ram_rd_data, combinational passthrough; meaningful only when o_rd_valid = 1.

Flags (all registered, computed from next-state pointers):
- count_next = wr_bin_sync - rd_bin_next, modulo 2^PTR_WIDTH.
- o_rd_count <= count_next.
- o_empty <= (count_next == 0).
- o_almost_empty <= (count_next <= ALMOST_EMPTY_TH).
- A read accepted in cycle N is reflected in the flags at the edge ending cycle N, so back-to-back reads can never pass empty.

Latency:
- A change on i_wr_ptr_gray reaches o_empty / o_rd_count after SYNC_STAGES+1 edges (3 with the default).
- Empty is pessimistic: it may stay high briefly after a write but never deasserts falsely.

Underflow:
- i_rd_en & o_empty -> o_underflow = 1 on the next cycle.
- No RAM access, pointer unchanged, o_rd_valid stays 0.

Simultaneous events:
- A read and a write-pointer update in the same cycle are both reflected in count_next.
- count_next never exceeds 2^ADDR_WIDTH given a legal write side.

Test Plan:
1. Async reset: assert i_rst mid-drain while o_rd_valid=1 -> o_rd_valid=0, o_empty=1, o_rd_ptr_gray=0, o_rd_count=0 immediately, without waiting for a clock edge.
2. Write visibility: i_wr_ptr_gray 00000->00001 -> o_empty falls exactly 3 edges later, o_rd_count=1, o_almost_empty=1.
3. Single read: with count=1, pulse i_rd_en -> same cycle o_ram_rd_en=1, o_ram_rd_addr=0.
   Next cycle: o_rd_valid=1, o_rd_data=RAM word 0, o_empty=1, o_rd_ptr_gray=00001, o_rd_count=0.
4. Full drain: i_wr_ptr_gray=11000 (binary 16) -> o_rd_count=16, o_almost_empty=0.
   Hold i_rd_en for 20 cycles -> exactly 16 accepts at addresses 0..15.
   o_almost_empty rises when count<=2; o_empty=1 after the 16th accept; final o_rd_ptr_gray=11000.
   o_underflow pulses for each of the 4 excess requests.
5. Wrap-around: stream 40 words through with the write pointer advancing by one Gray step per write.
   Read pointer passes binary 31->0 with Gray 10000->00000.
   Required: every o_rd_ptr_gray transition has Hamming distance 1, o_rd_count always matches the model, and no false empty or false non-empty.
6. Underflow isolation: i_rd_en=1 while empty -> o_underflow=1 for one cycle, o_ram_rd_en=0, pointer and o_rd_count unchanged.
